// File: rtl/ovl_proposition_bank.sv
// ovl_proposition_bank
//   Multi-channel registered proposition checker. Each cycle it evaluates
//   N_CH proposition taps. Checks are masked while the fabric configuration is
//   invalid, and for a programmable settle window after the configuration
//   becomes valid again. The block records sticky per-channel failures, the
//   first failing channel and a saturating failure count.
//
// Ports
//   clk                  in   rising-edge clock
//   rst                  in   asynchronous reset, active-high
//   enable[N_CH]         in   per-channel check enable
//   test_expr[N_CH]      in   per-channel proposition, 0 = violation
//   prev_config_invalid  in   1 = configuration not valid, suppress checks
//   clear                in   one-cycle pulse, drops sticky/first/count history
//   armed                out  checks qualified this cycle (state-decoded)
//   fire_vec[N_CH]       out  registered per-channel failure, 1-cycle latency
//   out                  out  OR of fire_vec
//   sticky[N_CH]         out  per-channel failure seen since reset/clear
//   first_valid          out  first_idx holds a captured failure
//   first_idx[IDX_W]     out  lowest failing channel of the first failing cycle
//   fail_count[CNT_W]    out  saturating count of qualified failures
//
// There is no valid/ready handshake here: every input is sampled on every
// rising clock edge, and every output is a registered level except armed and
// out, which are decoded from registers only.
module ovl_proposition_bank #(
  parameter int N_CH          = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8,
  localparam int IDX_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  enable,
  input  logic [N_CH-1:0]  test_expr,
  input  logic             prev_config_invalid,
  input  logic             clear,
  output logic             armed,
  output logic [N_CH-1:0]  fire_vec,
  output logic             out,
  output logic [N_CH-1:0]  sticky,
  output logic             first_valid,
  output logic [IDX_W-1:0] first_idx,
  output logic [CNT_W-1:0] fail_count
);

  // Settle counter sized to hold SETTLE_CYCLES-1.
  localparam int SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  // Popcount width and a sum width wide enough that count + popcount never wraps.
  localparam int PC_W        = $clog2(N_CH + 1);
  localparam int SUM_W       = CNT_W + PC_W + 1;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ARMED   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [SC_W-1:0] settle_cnt, settle_cnt_next;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INVALID;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    unique case (state)
      ST_INVALID: begin
        if (!prev_config_invalid) begin
          if (SETTLE_CYCLES == 0) begin
            state_next = ST_ARMED;
          end else begin
            state_next      = ST_SETTLE;
            settle_cnt_next = SC_W'(SETTLE_LOAD);
          end
        end
      end
      ST_SETTLE: begin
        if (prev_config_invalid) begin
          state_next = ST_INVALID;
        end else if (settle_cnt == '0) begin
          state_next = ST_ARMED;
        end else begin
          settle_cnt_next = settle_cnt - 1'b1;
        end
      end
      ST_ARMED: begin
        if (prev_config_invalid) state_next = ST_INVALID;
      end
      default: state_next = ST_INVALID;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // armed follows the state register only, so a pci pulse masks from the
  // following cycle onwards, never in the cycle it is first seen.
  always_comb begin
    armed = (state == ST_ARMED);
  end

  // ---------------- qualification and capture ----------------
  logic [N_CH-1:0]  qual;
  logic [PC_W-1:0]  qual_pop;
  logic [IDX_W-1:0] qual_low;
  logic [SUM_W-1:0] count_sum;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    qual     = enable & ~test_expr & {N_CH{armed}};
    qual_pop = '0;
    qual_low = '0;
    for (int i = 0; i < N_CH; i++) begin
      qual_pop = qual_pop + PC_W'(qual[i]);
    end
    // Scan from the top so the lowest set bit wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (qual[i]) qual_low = IDX_W'(i);
    end
    // Clear restarts the count from this cycle's failures.
    count_sum = (clear ? '0 : SUM_W'(fail_count)) + SUM_W'(qual_pop);
    if (count_sum > SUM_W'({CNT_W{1'b1}})) begin
      count_next = {CNT_W{1'b1}};
    end else begin
      count_next = count_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_vec    <= '0;
      sticky      <= '0;
      first_valid <= 1'b0;
      first_idx   <= '0;
      fail_count  <= '0;
    end else begin
      fire_vec   <= qual;
      fail_count <= count_next;
      if (clear) begin
        sticky      <= qual;
        first_valid <= |qual;
        first_idx   <= qual_low;
      end else begin
        sticky <= sticky | qual;
        if (!first_valid && (|qual)) begin
          first_valid <= 1'b1;
          first_idx   <= qual_low;
        end
      end
    end
  end

  assign out = |fire_vec;

endmodule

// File: tb/tb_ovl_proposition_bank.sv
module tb_ovl_proposition_bank;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] enable    = '0;
  logic [N-1:0] test_expr = '0;
  logic         pci       = 1'b1;
  logic         clear     = 1'b0;

  // Main instance (8-bit counter) and a narrow-counter instance on the same inputs.
  logic          armed, out, first_valid;
  logic [N-1:0]  fire_vec, sticky;
  logic [IW-1:0] first_idx;
  logic [7:0]    fail_count;

  logic          armed_s, out_s, first_valid_s;
  logic [N-1:0]  fire_vec_s, sticky_s;
  logic [IW-1:0] first_idx_s;
  logic [1:0]    fail_count_s;

  ovl_proposition_bank #(.N_CH(N), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .test_expr(test_expr),
    .prev_config_invalid(pci), .clear(clear), .armed(armed),
    .fire_vec(fire_vec), .out(out), .sticky(sticky), .first_valid(first_valid),
    .first_idx(first_idx), .fail_count(fail_count)
  );

  ovl_proposition_bank #(.N_CH(N), .SETTLE_CYCLES(S), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .test_expr(test_expr),
    .prev_config_invalid(pci), .clear(clear), .armed(armed_s),
    .fire_vec(fire_vec_s), .out(out_s), .sticky(sticky_s), .first_valid(first_valid_s),
    .first_idx(first_idx_s), .fail_count(fail_count_s)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // armed: true once pci has been sampled low on S+1 consecutive edges.
  // count: unsaturated total since last clear; each instance clamps on compare.
  int           m_run;
  logic [N-1:0] m_fire, m_sticky;
  logic         m_first_valid;
  int           m_first_idx;
  int           m_total;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_fire = '0; m_sticky = '0;
      m_first_valid = 1'b0; m_first_idx = 0; m_total = 0;
    end else begin
      logic [N-1:0] q;
      int pc, low;
      q   = (m_run >= S + 1) ? (enable & ~test_expr) : '0;
      pc  = 0;
      low = -1;
      for (int i = 0; i < N; i++) begin
        if (q[i]) begin
          pc++;
          if (low < 0) low = i;
        end
      end
      m_fire = q;
      if (clear) begin
        m_sticky = q; m_total = pc;
        m_first_valid = (pc > 0); m_first_idx = (low < 0) ? 0 : low;
      end else begin
        m_sticky = m_sticky | q; m_total = m_total + pc;
        if (!m_first_valid && pc > 0) begin
          m_first_valid = 1'b1; m_first_idx = low;
        end
      end
      if (pci) m_run = 0;
      else if (m_run < S + 1) m_run++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("armed", armed, (m_run >= S + 1));
    chk("fire_vec", fire_vec, m_fire);
    chk("out", out, |m_fire);
    chk("sticky", sticky, m_sticky);
    chk("first_valid", first_valid, m_first_valid);
    chk("first_idx", first_idx, m_first_idx);
    chk("fail_count", fail_count, (m_total > 255) ? 255 : m_total);
    chk("armed_s", armed_s, (m_run >= S + 1));
    chk("sticky_s", sticky_s, m_sticky);
    chk("fail_count_s", fail_count_s, (m_total > 3) ? 3 : m_total);
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [N-1:0] en, input logic [N-1:0] te,
                       input logic p, input logic c);
    enable = en; test_expr = te; pci = p; clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: reset with activity holds everything at zero.
    drive(4'hF, 4'h0, 1'b0, 1'b0);
    drive(4'hF, 4'h0, 1'b0, 1'b0);
    chk("t1_rst_armed", armed, 0);
    chk("t1_rst_fire", fire_vec, 0);
    chk("t1_rst_count", fail_count, 0);
    rst = 1'b0;
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    chk("t1_armed_c2", armed, 0);
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    chk("t1_armed_c3", armed, 1);

    // T2: single channel failure, one-cycle latency.
    drive(4'b0100, 4'b0000, 1'b0, 1'b0);
    chk("t2_fire", fire_vec, 4'b0100);
    chk("t2_out", out, 1);
    chk("t2_sticky", sticky, 4'b0100);
    chk("t2_first_idx", first_idx, 2);
    chk("t2_count", fail_count, 1);
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    chk("t2_fire_drop", fire_vec, 0);

    // T3: same-cycle pci does not mask; next cycle masked; settle window.
    drive(4'hF, 4'h0, 1'b1, 1'b0);
    chk("t3_same_cycle", fire_vec, 4'hF);
    drive(4'hF, 4'h0, 1'b1, 1'b0);
    chk("t3_masked", fire_vec, 0);
    chk("t3_count_held", fail_count, 5);
    drive(4'hF, 4'h0, 1'b0, 1'b0);
    drive(4'hF, 4'h0, 1'b0, 1'b0);
    drive(4'hF, 4'h0, 1'b0, 1'b0);
    chk("t3_settle_c3", fire_vec, 0);
    drive(4'hF, 4'h0, 1'b0, 1'b0);
    chk("t3_resume_c4", fire_vec, 4'hF);
    chk("t3_count", fail_count, 9);
    chk("t3_first_held", first_idx, 2);

    // T4: simultaneous failures after a clear.
    drive(4'h0, 4'hF, 1'b0, 1'b1);
    chk("t4_clear_count", fail_count, 0);
    chk("t4_clear_fv", first_valid, 0);
    drive(4'b1010, 4'b0000, 1'b0, 1'b0);
    chk("t4_first_idx", first_idx, 1);
    chk("t4_count", fail_count, 2);
    chk("t4_sticky", sticky, 4'b1010);

    // T5: saturation of the 2-bit counter.
    drive(4'h0, 4'hF, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) drive(4'b0001, 4'b0000, 1'b0, 1'b0);
    chk("t5_sat_small", fail_count_s, 3);
    chk("t5_main", fail_count, 6);
    drive(4'b0001, 4'b0000, 1'b0, 1'b0);
    chk("t5_sat_hold", fail_count_s, 3);

    // T6: clear with same-cycle failure, then invalidate during settle.
    drive(4'b0001, 4'b0000, 1'b0, 1'b1);
    chk("t6_sticky", sticky, 4'b0001);
    chk("t6_count", fail_count, 1);
    chk("t6_first_idx", first_idx, 0);
    chk("t6_first_valid", first_valid, 1);
    drive(4'h0, 4'hF, 1'b1, 1'b0);
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    drive(4'h0, 4'hF, 1'b1, 1'b0);
    chk("t6_invalid", armed, 0);
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    chk("t6_restart_c2", armed, 0);
    drive(4'hF, 4'h0, 1'b0, 1'b0);
    chk("t6_restart_c3", armed, 1);
    drive(4'b0110, 4'b0000, 1'b0, 1'b0);
    chk("t6_fire", fire_vec, 4'b0110);

    // Async reset mid-settle clears everything without a clock edge.
    drive(4'h0, 4'hF, 1'b1, 1'b0);
    drive(4'hF, 4'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_sticky", sticky, 0);
    chk("rst_async_count", fail_count, 0);
    chk("rst_async_fv", first_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    drive(4'h0, 4'hF, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
